// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/stop serial receiver (1 bit per clk, idle high) feeding a DEPTH-word FIFO.
// Optional even-parity bit between data and stop is enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              read,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dataout,
    output logic              empty,
    output logic              full,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t              state_q;
    logic [CNT_W-1:0]    bit_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_q, rd_q;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   dataout_q;
    logic                frame_err_q, overrun_q, parity_err_q;
    logic                good, pop, push, frame_evt, parity_evt;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic                par_bad_q;
    assign good       = state_q == STOP && sin && !par_bad_q;
    assign parity_evt = state_q == PARITY && (^{shift_q, sin});
`else
    assign good       = state_q == STOP && sin;
    assign parity_evt = 1'b0;
`endif

    assign frame_evt  = state_q == STOP && !sin;
    assign pop        = read && !empty;
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign push       = good && (!full || pop);
    assign count_d    = count_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    assign empty      = count_q == '0;
    assign full       = count_q == (ADDR_W+1)'(DEPTH);
    assign dataout    = dataout_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;

    // frame FSM: start detect, LSB-first data shift, optional parity, stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (!sin) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                end
                DATA: begin
                    shift_q[bit_q] <= sin;
                    bit_q          <= bit_q + 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    if (bit_q == CNT_W'(DATA_W-1)) state_q <= PARITY;
`else
                    if (bit_q == CNT_W'(DATA_W-1)) state_q <= STOP;
`endif
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                PARITY: begin
                    par_bad_q <= ^{shift_q, sin};
                    state_q   <= STOP;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO storage; written only on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= shift_q;
    end

    // FIFO pointers, occupancy and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            dataout_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q      <= rd_q + 1'b1;
                dataout_q <= mem_q[rd_q];
            end
            count_q <= count_d;
        end
    end

    // sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= frame_evt | (frame_err_q & ~err_clr);
            overrun_q    <= (good & ~push) | (overrun_q & ~err_clr);
            parity_err_q <= parity_evt | (parity_err_q & ~err_clr);
        end
    end
endmodule
